aidc_lite_comp_select: RTL and testbench
========================================

Name: aidc_lite_comp_select

Overview:
Per-cache-line scheduler that sits behind NUM_CAND code-concatenate engines, each running a different compression scheme with its own prefix. It captures each engine's word writes into private 8x64 banks and waits until every engine reports done. It then selects the shortest non-failed encoding, or falls back to the raw 512-bit line. The chosen words are drained to the downstream link over a valid/ready handshake.

Parameters:
NUM_CAND, 2, number of candidate engines (legal 2..4)
WORDS, 8, maximum 64-bit words per encoded block (fixed 8; addr width 3)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start_i  in  1  new line begins; same cycle as candidates' sop
raw_data_i  in  512  uncompressed line, sampled on accepted start_i
cand_valid_i  in  NUM_CAND  per-candidate word write strobe
cand_addr_i  in  3*NUM_CAND  word index, candidate c at [3c+2:3c]
cand_data_i  in  64*NUM_CAND  word data, candidate c at [64c+63:64c]
cand_done_i  in  NUM_CAND  level done from engine
cand_fail_i  in  NUM_CAND  level fail from engine, valid while done
out_valid_o  out  1  output word valid
out_ready_i  in  1  downstream accepts word
out_data_o  out  64  output word
out_last_o  out  1  final word of block
out_sel_o  out  3  chosen source: c = candidate c, NUM_CAND = raw
out_wcnt_o  out  4  word count of chosen block (1..8)
busy_o  out  1  high from accepted start until last handshake
ovf_o  out  1  one-cycle pulse: start_i dropped

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, out_sel_o=0, out_wcnt_o=0, busy_o=0, ovf_o=0. FSM=IDLE. All per-candidate flags and counts are cleared. Bank contents are don't-care.
- FSM states: IDLE -> COLLECT -> DECIDE -> DRAIN -> IDLE.
- IDLE: start_i=1 captures raw_data_i, clears per-candidate seen_busy/done_f/fail_f/wcnt, and moves to COLLECT. busy_o=1 from the next cycle.
- start_i in any state other than IDLE is dropped. ovf_o pulses the next cycle. State is unchanged.
- COLLECT, per candidate c:
  - cand_valid_i[c] writes bank[c][addr] and sets wcnt[c] = max(wcnt[c], addr+1).
  - Writes are also captured in the start_i cycle itself.
- Engine done is a level signal that is still high from the previous line when start_i arrives. It deasserts one cycle later.
  - seen_busy[c] sets when cand_done_i[c]=0.
  - done_f[c] sets on cand_done_i[c]=1 && seen_busy[c]; fail_f[c] is sampled from cand_fail_i[c] on that same cycle.
  - A write arriving in the same cycle as done is captured before the decision.
- When all done_f are set -> DECIDE (one cycle).
- DECIDE selection:
  - Among candidates with !fail_f and wcnt>=1, pick the minimum wcnt; ties go to the lowest index.
  - If none qualifies, sel=NUM_CAND (raw) and wcnt=8.
  - out_sel_o and out_wcnt_o are registered here and held until the next accepted start.
- DRAIN:
  - out_valid_o=1 starting the cycle after DECIDE.
  - Word k = bank[sel][k]; for raw, word k = raw[511-64k:448-64k].
  - k advances only on out_valid_o && out_ready_i. out_data_o is stable while stalled.
  - out_last_o=1 when k = wcnt-1.
  - The last handshake -> IDLE: out_valid_o=0 and busy_o=0 in the following cycle.
- Latency: all done_f set at cycle T -> DECIDE at T+1 -> first word valid at T+2. Maximum throughput is one word per cycle.
- Back-to-back lines: a start_i in the same cycle as the final handshake is dropped (state is not yet IDLE).
- Reset asserted mid-operation returns to the reset values on the next edge. Partial bank data is discarded.

Test Plan:
- Single line, NUM_CAND=2: cand0 writes addr 0..4 then done, fail=0; cand1 writes 0..2 then done, fail=0 -> sel=1, wcnt=3, three words equal cand1 bank[0..2], last on the third; first valid exactly 2 cycles after the later done.
- Tie: both candidates write 4 words, neither fails -> sel=0, wcnt=4.
- All fail: both engines report done with fail=1 -> sel=2 (raw), wcnt=8, words = raw_data_i[511:448] first … [63:0] last.
- Stale done: cand_done_i held at 1 across start_i for 3 cycles, then deasserts and reasserts -> no DECIDE until the reassertion; wcnt reflects only the new writes.
- Backpressure: out_ready_i toggles 1,0,0,1,... during DRAIN -> no word lost or duplicated; out_data_o constant while stalled.
- Overflow and reset: start_i pulsed during DRAIN -> ovf_o=1 for one cycle, drain unaffected; rst_n low mid-COLLECT -> all outputs return to reset values next cycle, and a subsequent start works normally.

Source files
------------

// File: rtl/aidc_lite_comp_select.sv
// Per-line scheduler: collects candidate encodings into private banks, picks the
// shortest non-failed one (or the raw line) and drains it over valid/ready.
module aidc_lite_comp_select #(
    parameter int NUM_CAND = 2,
    parameter int WORDS    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [511:0]             raw_data_i,
    input  logic [NUM_CAND-1:0]      cand_valid_i,
    input  logic [3*NUM_CAND-1:0]    cand_addr_i,
    input  logic [64*NUM_CAND-1:0]   cand_data_i,
    input  logic [NUM_CAND-1:0]      cand_done_i,
    input  logic [NUM_CAND-1:0]      cand_fail_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_data_o,
    output logic                     out_last_o,
    output logic [2:0]               out_sel_o,
    output logic [3:0]               out_wcnt_o,
    output logic                     busy_o,
    output logic                     ovf_o
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [511:0]        r_raw;
    logic [63:0]         r_bank [NUM_CAND][WORDS];
    logic [NUM_CAND-1:0] r_seen_busy;
    logic [NUM_CAND-1:0] r_done_f;
    logic [NUM_CAND-1:0] r_fail_f;
    logic [3:0]          r_wcnt [NUM_CAND];
    logic [2:0]          r_sel;
    logic [3:0]          r_owcnt;
    logic [2:0]          r_k;
    logic                r_ovf;

    logic                w_start_acc;
    logic                w_capture;
    logic                w_is_last;
    logic [3:0]          w_addr1 [NUM_CAND];
    logic [2:0]          w_best_sel;
    logic [3:0]          w_best_cnt;
    logic                w_found;
    logic [63:0]         w_bank_word;
    logic [2:0]          w_raw_idx;

    assign w_start_acc = start_i && (r_state == S_IDLE);
    assign w_capture   = w_start_acc || (r_state == S_COLLECT);
    assign w_is_last   = (r_state == S_DRAIN) && ({1'b0, r_k} == (r_owcnt - 4'd1));

    always_comb begin
        for (int c = 0; c < NUM_CAND; c++) begin
            w_addr1[c] = {1'b0, cand_addr_i[3*c +: 3]} + 4'd1;
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_sel = 3'(NUM_CAND);
        w_best_cnt = 4'd8;
        w_found    = 1'b0;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (!r_fail_f[c] && (r_wcnt[c] != 4'd0) && (!w_found || (r_wcnt[c] < w_best_cnt))) begin
                w_found    = 1'b1;
                w_best_sel = 3'(c);
                w_best_cnt = r_wcnt[c];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_state_nxt = S_COLLECT;
            S_COLLECT: if (&r_done_f) w_state_nxt = S_DECIDE;
            S_DECIDE:  w_state_nxt = S_DRAIN;
            S_DRAIN:   if (out_ready_i && w_is_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_seen_busy <= '0;
            r_done_f    <= '0;
            r_fail_f    <= '0;
            r_sel       <= 3'd0;
            r_owcnt     <= 4'd0;
            r_k         <= 3'd0;
            r_ovf       <= 1'b0;
            for (int c = 0; c < NUM_CAND; c++) r_wcnt[c] <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= start_i && (r_state != S_IDLE);
            // A done still high from the previous line only counts after it has dropped once.
            for (int c = 0; c < NUM_CAND; c++) begin
                if (w_start_acc) begin
                    r_seen_busy[c] <= !cand_done_i[c];
                    r_done_f[c]    <= 1'b0;
                    r_fail_f[c]    <= 1'b0;
                    r_wcnt[c]      <= cand_valid_i[c] ? w_addr1[c] : 4'd0;
                end else if (r_state == S_COLLECT) begin
                    if (!cand_done_i[c]) r_seen_busy[c] <= 1'b1;
                    if (cand_done_i[c] && r_seen_busy[c] && !r_done_f[c]) begin
                        r_done_f[c] <= 1'b1;
                        r_fail_f[c] <= cand_fail_i[c];
                    end
                    if (cand_valid_i[c] && (w_addr1[c] > r_wcnt[c])) r_wcnt[c] <= w_addr1[c];
                end
            end
            if (r_state == S_DECIDE) begin
                r_sel   <= w_best_sel;
                r_owcnt <= w_best_cnt;
                r_k     <= 3'd0;
            end else if ((r_state == S_DRAIN) && out_ready_i) begin
                r_k <= r_k + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_acc) r_raw <= raw_data_i;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (w_capture && cand_valid_i[c]) r_bank[c][cand_addr_i[3*c +: 3]] <= cand_data_i[64*c +: 64];
        end
    end

    always_comb begin
        w_bank_word = 64'd0;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (r_sel == 3'(c)) w_bank_word = r_bank[c][r_k];
        end
    end

    // Raw word 0 is the most significant 64 bits of the line.
    assign w_raw_idx = 3'd7 - r_k;

    assign out_valid_o = (r_state == S_DRAIN);
    assign out_last_o  = w_is_last;
    assign out_data_o  = !out_valid_o ? 64'd0 :
                         (r_sel >= 3'(NUM_CAND)) ? r_raw[{w_raw_idx, 6'b0} +: 64] : w_bank_word;
    assign out_sel_o   = r_sel;
    assign out_wcnt_o  = r_owcnt;
    assign busy_o      = (r_state != S_IDLE);
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_aidc_lite_comp_select.sv
// Directed bench for aidc_lite_comp_select with NUM_CAND=2.
module tb_aidc_lite_comp_select;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [511:0] raw_data_i;
    logic [1:0]   cand_valid_i;
    logic [5:0]   cand_addr_i;
    logic [127:0] cand_data_i;
    logic [1:0]   cand_done_i;
    logic [1:0]   cand_fail_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [63:0]  out_data_o;
    logic         out_last_o;
    logic [2:0]   out_sel_o;
    logic [3:0]   out_wcnt_o;
    logic         busy_o;
    logic         ovf_o;

    int checks   = 0;
    int failures = 0;
    int line     = 0;
    logic [511:0] raw_line;

    aidc_lite_comp_select #(.NUM_CAND(2), .WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .raw_data_i(raw_data_i),
        .cand_valid_i(cand_valid_i), .cand_addr_i(cand_addr_i), .cand_data_i(cand_data_i),
        .cand_done_i(cand_done_i), .cand_fail_i(cand_fail_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_sel_o(out_sel_o), .out_wcnt_o(out_wcnt_o),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cword(input int c, input int a, input int ln);
        return 64'hC000_0000_0000_0000 + (64'(c) << 40) + (64'(ln) << 16) + 64'(a);
    endfunction

    task automatic new_raw();
        line++;
        for (int k = 0; k < 8; k++) raw_line[64*(7-k) +: 64] = 64'hAAAA_0000_0000_0000 + (64'(line) << 16) + 64'(k);
        raw_data_i = raw_line;
    endtask

    task automatic set_write(input int c, input logic v, input int a);
        cand_valid_i[c]        = v;
        cand_addr_i[3*c +: 3]  = 3'(a);
        cand_data_i[64*c +: 64] = cword(c, a, line);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_data"},  out_data_o,       64'd0);
        chk({tag, "_last"},  64'(out_last_o),  64'd0);
        chk({tag, "_sel"},   64'(out_sel_o),   64'd0);
        chk({tag, "_wcnt"},  64'(out_wcnt_o),  64'd0);
        chk({tag, "_busy"},  64'(busy_o),      64'd0);
        chk({tag, "_ovf"},   64'(ovf_o),       64'd0);
    endtask

    // Stale done during start, n0/n1 sequential writes, then done with given fail bits.
    task automatic run_collect(input int n0, input int n1, input logic f0, input logic f1);
        int n;
        new_raw();
        start_i = 1'b1; cand_done_i = 2'b11; cand_valid_i = 2'b00;
        tick();
        start_i = 1'b0; cand_done_i = 2'b00;
        n = (n0 > n1) ? n0 : n1;
        if (n < 1) n = 1;
        for (int i = 0; i < n; i++) begin
            set_write(0, i < n0, i);
            set_write(1, i < n1, i);
            tick();
            if (i == 0) chk("busy_collect", 64'(busy_o), 64'd1);
        end
        cand_valid_i = 2'b00; cand_done_i = 2'b11; cand_fail_i = {f1, f0};
        tick();
        chk("lat_T", 64'(out_valid_o), 64'd0);
        tick();
        chk("lat_T1", 64'(out_valid_o), 64'd0);
        tick();
        chk("lat_T2", 64'(out_valid_o), 64'd1);
    endtask

    task automatic drain(input int esel, input int ecnt, input logic bp, input int ovf_cyc);
        int k = 0;
        logic fin = 1'b0;
        logic [63:0] exp;
        chk("sel", 64'(out_sel_o), 64'(esel));
        chk("wcnt", 64'(out_wcnt_o), 64'(ecnt));
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            out_ready_i = bp ? ((cyc % 3) == 0) : 1'b1;
            start_i = (cyc == ovf_cyc);
            if (ovf_cyc >= 0 && cyc == ovf_cyc + 1) chk("ovf_pulse", 64'(ovf_o), 64'd1);
            if (ovf_cyc >= 0 && cyc == ovf_cyc + 2) chk("ovf_clear", 64'(ovf_o), 64'd0);
            exp = (esel == 2) ? raw_line[64*(7-k) +: 64] : cword(esel, k, line);
            chk("drain_valid", 64'(out_valid_o), 64'd1);
            chk("drain_data", out_data_o, exp);
            chk("drain_last", 64'(out_last_o), 64'(k == ecnt - 1));
            if (out_ready_i) begin
                if (k == ecnt - 1) fin = 1'b1;
                k++;
            end
            tick();
        end
        start_i = 1'b0;
        chk("drain_count", 64'(k), 64'(ecnt));
        chk("post_valid", 64'(out_valid_o), 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        chk("post_sel_hold", 64'(out_sel_o), 64'(esel));
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; raw_data_i = '0; cand_valid_i = '0; cand_addr_i = '0;
        cand_data_i = '0; cand_done_i = 2'b11; cand_fail_i = '0; out_ready_i = 1'b0;
        raw_line = '0;
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Shorter candidate 1 wins.
        run_collect(5, 3, 1'b0, 1'b0);
        drain(1, 3, 1'b0, -1);

        // Tie goes to candidate 0; drained under backpressure.
        run_collect(4, 4, 1'b0, 1'b0);
        drain(0, 4, 1'b1, -1);

        // Shorter candidate failed, longer one wins.
        run_collect(6, 2, 1'b0, 1'b1);
        drain(0, 6, 1'b0, -1);

        // Both fail: raw fallback, with a dropped start during the drain.
        run_collect(2, 6, 1'b1, 1'b1);
        drain(2, 8, 1'b0, 2);
        chk("ovf_idle", 64'(ovf_o), 64'd0);

        // Reset in the middle of collection.
        new_raw();
        start_i = 1'b1; cand_done_i = 2'b11;
        tick();
        start_i = 1'b0; cand_done_i = 2'b00;
        set_write(0, 1'b1, 0);
        tick();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0; cand_valid_i = 2'b00; cand_done_i = 2'b11;
        tick();
        check_reset_values("midrst");
        rst_n = 1'b1;
        tick();

        // Stale done held for three cycles across start.
        new_raw();
        start_i = 1'b1; cand_done_i = 2'b11; cand_fail_i = 2'b00;
        set_write(0, 1'b1, 0); set_write(1, 1'b1, 0);
        tick();
        start_i = 1'b0;
        set_write(0, 1'b1, 1); set_write(1, 1'b1, 1);
        tick();
        set_write(0, 1'b0, 0); set_write(1, 1'b1, 2);
        tick();
        chk("stale_busy", 64'(busy_o), 64'd1);
        chk("stale_novalid0", 64'(out_valid_o), 64'd0);
        cand_done_i = 2'b00;
        set_write(1, 1'b1, 3);
        tick();
        chk("stale_novalid1", 64'(out_valid_o), 64'd0);
        cand_valid_i = 2'b00; cand_done_i = 2'b11;
        tick();
        chk("stale_lat_T", 64'(out_valid_o), 64'd0);
        tick();
        chk("stale_lat_T1", 64'(out_valid_o), 64'd0);
        tick();
        chk("stale_lat_T2", 64'(out_valid_o), 64'd1);
        drain(0, 2, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
